// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo counter slice.
// Saturate-mode encodings and prescaler width.
package mod_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int PSC_W = 8;

endpackage

// File: rtl/mod_prescaler.sv
// Enable prescaler: pulses tick once every PRESCALE enabled cycles.
// clr and reset both restart the full period.
module mod_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PSC_W-1:0] LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == LAST);
  assign tick = en & ~clr & ~reset & wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with load, prescaled enable,
// wrap or saturate at terminal, and sticky overflow flag.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     SATURATE = 0,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] r_reg,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam bit SAT = (SATURATE == int'(MODE_SAT));

  logic             tick;
  logic             at_term;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] ld_v;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] r_next;

  mod_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_psc (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  always_comb begin
    term    = up ? MAXV : '0;
    at_term = (r_reg == term);
    ld_v    = (load_val > MAXV) ? MAXV : load_val;
    stepped = up ? r_reg + 1'b1 : r_reg - 1'b1;
    // terminal step either holds or jumps to the opposite end
    if (at_term) begin
      stepped = SAT ? r_reg : (up ? '0 : MAXV);
    end
    r_next = r_reg;
    unique case (1'b1)
      load:    r_next = ld_v;
      tick:    r_next = stepped;
      default: r_next = r_reg;
    endcase
  end

  assign tc = tick & at_term & ~load & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg <= '0;
    end else begin
      r_reg <= r_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (tc) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three parameter sets driven in parallel,
// checked against a cycle-level arithmetic model.
module tb_mod_counter;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset, en, up, load, clr_ovf;
  logic [3:0] load_val;
  logic [3:0] rr [N];
  logic       tcv [N];
  logic       ovv [N];

  int mm [N];
  int ss [N];
  int pp [N];
  int mv [N];
  int mph [N];
  bit mov [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_counter u0 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
    .r_reg(rr[0]), .tc(tcv[0]), .ovf(ovv[0])
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) u1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
    .r_reg(rr[1]), .tc(tcv[1]), .ovf(ovv[1])
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) u2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf),
    .r_reg(rr[2]), .tc(tcv[2]), .ovf(ovv[2])
  );

  task automatic cyc(input bit rs, input bit e, input bit u,
                     input bit l, input int lv, input bit c,
                     input string tag);
    bit tk, tcx;
    int term;
    reset    = rs;
    en       = e;
    up       = u;
    load     = l;
    load_val = 4'(lv);
    clr_ovf  = c;
    #1;
    for (int k = 0; k < N; k++) begin
      term = u ? mm[k] - 1 : 0;
      tk   = e && !l && !rs && (mph[k] == pp[k] - 1);
      tcx  = tk && (mv[k] == term);
      checks++;
      assert (int'(rr[k]) === mv[k]) else begin
        errors++;
        $error("FAIL %s u%0d r_reg got %0d want %0d", tag, k, rr[k], mv[k]);
      end
      checks++;
      assert (ovv[k] === mov[k]) else begin
        errors++;
        $error("FAIL %s u%0d ovf got %0b want %0b", tag, k, ovv[k], mov[k]);
      end
      checks++;
      assert (tcv[k] === tcx) else begin
        errors++;
        $error("FAIL %s u%0d tc got %0b want %0b", tag, k, tcv[k], tcx);
      end
      if (rs) begin
        mv[k]  = 0;
        mph[k] = 0;
        mov[k] = 0;
      end else begin
        if (tcx) mov[k] = 1;
        else if (c) mov[k] = 0;
        if (l) begin
          mv[k]  = (lv > mm[k] - 1) ? mm[k] - 1 : lv;
          mph[k] = 0;
        end else if (e) begin
          mph[k] = (mph[k] + 1) % pp[k];
          if (tk) begin
            if (tcx && ss[k] == 1) mv[k] = mv[k];
            else if (u) mv[k] = (mv[k] + 1) % mm[k];
            else mv[k] = (mv[k] + mm[k] - 1) % mm[k];
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    mm = '{16, 10, 10};
    ss = '{0, 1, 0};
    pp = '{1, 1, 3};
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
    load_val = '0; clr_ovf = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      mv[k] = 0; mph[k] = 0; mov[k] = 0;
    end

    cyc(0, 0, 1, 0, 0, 0, "reset_state");
    for (int i = 0; i < 17; i++) cyc(0, 1, 1, 0, 0, 0, "run_up");
    cyc(0, 0, 1, 0, 0, 0, "ovf_hold");

    cyc(0, 0, 1, 1, 15, 0, "load_top");
    cyc(0, 1, 1, 0, 0, 1, "clr_vs_tc");
    cyc(0, 0, 1, 0, 0, 0, "set_wins");

    cyc(1, 0, 0, 0, 0, 0, "rst_a");
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0, "sat_down");
    cyc(0, 0, 0, 0, 0, 1, "clr_ovf");
    cyc(0, 0, 0, 0, 0, 0, "ovf_clear");

    cyc(0, 1, 1, 1, 13, 0, "load_clamp");
    cyc(0, 0, 1, 0, 0, 0, "after_load");

    cyc(1, 0, 1, 0, 0, 0, "rst_b");
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0, "psc_a");
    for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 0, 0, "psc_gap");
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, 0, "psc_b");
    cyc(0, 0, 1, 0, 0, 0, "psc_end");

    cyc(0, 0, 1, 1, 7, 0, "load7");
    cyc(0, 1, 0, 0, 0, 0, "part_step");
    cyc(1, 1, 1, 1, 7, 0, "rst_over_load");
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0, "post_rst");

    cyc(0, 0, 1, 1, 9, 0, "load9");
    for (int i = 0; i < 6; i++) cyc(0, 1, i[0], 0, 0, 0, "dir_flip");

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(39) == 0), ($urandom_range(3) != 0),
          1'($urandom_range(1)), ($urandom_range(9) == 0),
          int'($urandom_range(15)), ($urandom_range(7) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 1..32.
REQ-002 Parameter MODULUS, default 16: count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 means wrap at terminal value, 1 means hold at terminal value.
REQ-004 Parameter PRESCALE, default 1: number of enabled cycles per count step, legal range 1..256.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 Port en, input, 1 bit: count enable.
REQ-008 Port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-009 Port load, input, 1 bit: synchronous parallel load strobe.
REQ-010 Port load_val, input, WIDTH bits: value loaded when load=1.
REQ-011 Port clr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-012 Port r_reg, output, WIDTH bits: registered count value.
REQ-013 Port tc, output, 1 bit: combinational terminal-count strobe.
REQ-014 Port ovf, output, 1 bit: registered sticky overflow/underflow flag.

Function
REQ-015 Update priority in each cycle SHALL be reset, then load, then count.
REQ-016 load=1 SHALL set r_reg to min(load_val, MODULUS-1) on the next edge, regardless of en, and clear the prescaler.
REQ-017 The prescaler SHALL advance only in cycles with en=1 and load=0, and SHALL generate tick when it reaches PRESCALE-1, then return to 0; with PRESCALE=1, tick=en.
REQ-018 A step SHALL occur only on tick: r_reg+1 if up=1, r_reg-1 if up=0.
REQ-019 The terminal value SHALL be MODULUS-1 when up=1 and 0 when up=0.
REQ-020 A step at the terminal value with SATURATE=0 SHALL wrap r_reg to 0 (up) or MODULUS-1 (down).
REQ-021 A step at the terminal value with SATURATE=1 SHALL leave r_reg unchanged.
REQ-022 tc SHALL equal tick AND (r_reg == terminal value) AND NOT load, in the same cycle, with no added latency.
REQ-023 ovf SHALL be set on the edge following any cycle with tc=1.
REQ-024 ovf SHALL clear on the edge following a cycle with clr_ovf=1 only if tc=0 in that cycle; set wins over clear.
REQ-025 A direction change mid-count SHALL take effect on the next tick, with no change to the prescaler phase.
REQ-026 en=0 SHALL freeze both r_reg and the prescaler count.
REQ-027 Arithmetic SHALL be modulo-MODULUS; r_reg SHALL never hold a value ≥ MODULUS.

Reset
REQ-028 reset=1 at a rising edge SHALL set r_reg=0, ovf=0 and prescaler=0, overriding load and en.
REQ-029 tc SHALL be 0 in any cycle with reset=1.
REQ-030 Reset asserted mid-prescale or mid-count SHALL discard all partial state; counting restarts from the full PRESCALE period.

Structure
REQ-031 A shared package SHALL hold the SATURATE mode encodings (MODE_WRAP=0, MODE_SAT=1) and the prescaler width constant (8 bits).
REQ-032 The prescaler SHALL be a sub-module named mod_prescaler, with ports clk, reset, en, clr and tick.
REQ-033 The top level SHALL contain the count register, the terminal and clamp logic, and the ovf flag.

Verification
REQ-034 Default parameters, reset for 1 cycle, then en=1, up=1 for 17 cycles -> r_reg runs 0..15 then 0; tc=1 only at r_reg=15; ovf=1 from the following edge.
REQ-035 SATURATE=1, MODULUS=10, up=0 from r_reg=0 -> r_reg stays 0, tc=1 each cycle, ovf=1; then clr_ovf=1 with en=0 -> ovf=0.
REQ-036 MODULUS=10, load=1 with load_val=13 -> r_reg=9; the same cycle with en=1 -> no count step and tc=0.
REQ-037 PRESCALE=3, en=1 for 9 cycles with en=0 for 2 cycles inserted after the 4th -> r_reg advances exactly 3 times, and only on every 3rd enabled cycle.
REQ-038 reset asserted for one cycle during load=1 and en=1 at r_reg=7 -> r_reg=0, ovf=0, tc=0; the next step occurs PRESCALE enabled cycles later.
REQ-039 clr_ovf=1 and tc=1 in the same cycle -> ovf=1 after the edge.
